// File: rtl/coherence_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coherence_req_arbiter
// Brief    : Ordering point for the snooping coherence bus. Grants one
//            GETS/GETM/PUTM request per cycle (round-robin or fixed
//            priority), broadcasts it as a registered transaction and holds
//            further requests to a line until memory reports it complete.
// Revision : 1.0 - initial release
// ============================================================================
module coherence_req_arbiter #(
    parameter int NUM_REQ     = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 2,
    parameter int INFLIGHT    = 4,
    parameter int RR_MODE     = 1,
    parameter int SRC_WIDTH   = $clog2(NUM_REQ) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*2-1:0]           req_tx,
    output logic                           bcast_valid,
    input  logic                           bcast_ready,
    output logic [SRC_WIDTH-1:0]           bcast_source,
    output logic [ADDR_WIDTH-1:0]          bcast_addr,
    output logic [1:0]                     bcast_tx,
    input  logic                           done_valid,
    input  logic [ADDR_WIDTH-1:0]          done_addr,
    output logic [$clog2(INFLIGHT):0]      inflight_count,
    output logic                           err_unmatched
);

    localparam int KEY_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(INFLIGHT) + 1;

    logic [INFLIGHT-1:0]   tbl_vld_q, tbl_vld_d;
    logic [KEY_W-1:0]      tbl_key_q [INFLIGHT];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  bcast_valid_q;
    logic [SRC_WIDTH-1:0]  bcast_source_q;
    logic [ADDR_WIDTH-1:0] bcast_addr_q;
    logic [1:0]            bcast_tx_q;
    logic                  err_q;

    logic [CNT_W-1:0]      cnt;
    logic [NUM_REQ-1:0]    elig;
    logic                  gnt_found;
    int                    gnt_idx;
    logic [KEY_W-1:0]      gnt_key;
    int                    free_idx;
    logic [INFLIGHT-1:0]   done_hit;

    // Low offset bits of the completion address never take part in line matching.
    if (OFFSET_BITS > 0) begin : g_unused_offset
        logic unused_done_offset;
        assign unused_done_offset = ^done_addr[OFFSET_BITS-1:0];
    end

    // Occupancy is derived directly from the valid bits so it can never drift.
    always_comb begin
        cnt = '0;
        for (int e = 0; e < INFLIGHT; e++) begin
            cnt = cnt + CNT_W'(tbl_vld_q[e]);
        end
    end

    // Per-requestor eligibility against registered table state and the output slot.
    always_comb begin
        logic hit;
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit = 1'b0;
            for (int e = 0; e < INFLIGHT; e++) begin
                if (tbl_vld_q[e] &&
                    tbl_key_q[e] == req_addr[i*ADDR_WIDTH + OFFSET_BITS +: KEY_W]) begin
                    hit = 1'b1;
                end
            end
            elig[i] = !rst && req_valid[i] && (req_tx[2*i +: 2] != 2'd3) && !hit &&
                      (cnt < CNT_W'(INFLIGHT)) && (!bcast_valid_q || bcast_ready);
        end
    end

    // Winner selection: rotating search from the pointer, or lowest index first.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (RR_MODE != 0) ? ((int'(ptr_q) + k) % NUM_REQ) : k;
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        req_ready = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = PTR_W'((gnt_idx + 1) % NUM_REQ);
        end
        gnt_key = req_addr[gnt_idx*ADDR_WIDTH + OFFSET_BITS +: KEY_W];
    end

    // Table bookkeeping: completions clear matching entries, grants fill the lowest free one.
    always_comb begin
        free_idx = 0;
        for (int e = INFLIGHT - 1; e >= 0; e--) begin
            if (!tbl_vld_q[e]) begin
                free_idx = e;
            end
        end
        done_hit = '0;
        for (int e = 0; e < INFLIGHT; e++) begin
            done_hit[e] = done_valid && tbl_vld_q[e] &&
                          (tbl_key_q[e] == done_addr[ADDR_WIDTH-1:OFFSET_BITS]);
        end
        tbl_vld_d = tbl_vld_q & ~done_hit;
        // A grant implies spare capacity, so free_idx is a genuinely empty slot
        // and cannot collide with an entry being released this cycle.
        if (gnt_found) begin
            tbl_vld_d[free_idx] = 1'b1;
        end
    end

    // State registers: table, pointer, held broadcast and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld_q      <= '0;
            ptr_q          <= '0;
            bcast_valid_q  <= 1'b0;
            bcast_source_q <= '0;
            bcast_addr_q   <= '0;
            bcast_tx_q     <= '0;
            err_q          <= 1'b0;
            for (int e = 0; e < INFLIGHT; e++) begin
                tbl_key_q[e] <= '0;
            end
        end else begin
            tbl_vld_q <= tbl_vld_d;
            ptr_q     <= ptr_d;
            if (gnt_found) begin
                tbl_key_q[free_idx] <= gnt_key;
                bcast_valid_q       <= 1'b1;
                bcast_source_q      <= SRC_WIDTH'(gnt_idx);
                bcast_addr_q        <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                bcast_tx_q          <= req_tx[2*gnt_idx +: 2];
            end else if (bcast_ready) begin
                bcast_valid_q <= 1'b0;
            end
            if (done_valid && (done_hit == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bcast_valid    = bcast_valid_q;
    assign bcast_source   = bcast_source_q;
    assign bcast_addr     = bcast_addr_q;
    assign bcast_tx       = bcast_tx_q;
    assign inflight_count = cnt;
    assign err_unmatched  = err_q;

endmodule
`default_nettype wire
